// File: rtl/opsel_pkg.sv
// Shared constants and state encoding for the operand-A select/skid stage.
package opsel_pkg;

  localparam int SRC_ADDR  = 0;
  localparam int SRC_DATA1 = 1;
  localparam int SRC_IMM   = 2;
  localparam int SRC_FWD   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } opsel_state_t;

endpackage

// File: rtl/operand_sel_skid_if.sv
// Handshake/bus bundle between decode (master) and the operand select stage (slave).
interface operand_sel_skid_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         sel;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               occupancy;
  logic                     sel_err;

  modport master (
    output src_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid, occupancy, sel_err
  );

  modport slave (
    input  src_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid, occupancy, sel_err
  );
endinterface

// File: rtl/opsel_mux.sv
// Combinational N:1 operand mux; range check enabled by OPSEL_RANGE_CHK_EN.
module opsel_mux
  import opsel_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [SEL_W-1:0]         sel_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     oor_o
);

  always_comb begin
    data_o = src_data_i[WIDTH-1:0];
    oor_o  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_i == SEL_W'(i)) data_o = src_data_i[i*WIDTH +: WIDTH];
    end
`ifdef OPSEL_RANGE_CHK_EN
    if (32'(sel_i) >= NUM_SRC) begin
      oor_o  = 1'b1;
      data_o = '0;
    end
`endif
  end

endmodule

// File: rtl/operand_sel_skid.sv
// Operand-A select stage with 2-entry skid output (main + skid register).
// Optional out-of-range select checking under OPSEL_RANGE_CHK_EN.
module operand_sel_skid
  import opsel_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input logic               clk,
  input logic               rst_n,
  operand_sel_skid_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_FULL  = FULL;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q;
  logic             out_valid;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] mux_data;
  logic             mux_oor;

  opsel_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) u_mux (
    .src_data_i (bus.src_data),
    .sel_i      (bus.sel),
    .data_o     (mux_data),
    .oor_o      (mux_oor)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_data_d = mux_data;
          main_sel_d  = bus.sel;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_d     = ST_FULL;
          skid_data_d = mux_data;
          skid_sel_d  = bus.sel;
        end else if (!accept && pop) begin
          state_d = ST_EMPTY;
        end else if (accept && pop) begin
          main_data_d = mux_data;
          main_sel_d  = bus.sel;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; stale data in the regs is harmless once invalid.
    if (bus.flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= (state_d != ST_FULL);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_data_q;
  assign bus.out_sel   = main_sel_q;
  assign bus.occupancy = state_q;

`ifdef OPSEL_RANGE_CHK_EN
  logic sel_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && mux_oor && !bus.flush) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  logic unused_oor;
  assign unused_oor  = mux_oor;
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_sel_skid.sv
// Bench for operand_sel_skid: directed scenarios plus random traffic against a queue model.
module tb_operand_sel_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_sel_skid_if #(.WIDTH(32), .NUM_SRC(4)) bus ();
  operand_sel_skid_if #(.WIDTH(32), .NUM_SRC(3)) bus3 ();

  operand_sel_skid #(.WIDTH(32), .NUM_SRC(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  operand_sel_skid #(.WIDTH(32), .NUM_SRC(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [31:0] src_arr [4];
  logic [31:0] src3_arr [3];
  assign bus.src_data  = {src_arr[3], src_arr[2], src_arr[1], src_arr[0]};
  assign bus3.src_data = {src3_arr[2], src3_arr[1], src3_arr[0]};

  int n_asserts = 0;
  int n_fail = 0;

  // reference model: ordered list of held operands {data, sel}
  logic [33:0] mq [$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    check("occupancy", 64'(bus.occupancy), 64'(mq.size()));
    check("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    check("sel_err_pow2", 64'(bus.sel_err), 64'(0));
    if (mq.size() > 0) begin
      check("out_data", 64'(bus.out_data), 64'(mq[0][33:2]));
      check("out_sel", 64'(bus.out_sel), 64'(mq[0][1:0]));
    end
  endtask

  task automatic drive(logic v, logic [1:0] s, logic rdy, logic fl);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic tick();
    bit acc, pp;
    logic [33:0] e;
    acc = bus.in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && bus.out_ready;
    e   = {src_arr[bus.sel], bus.sel};
    @(posedge clk);
    if (bus.flush) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
    check_model();
  endtask

  logic [31:0] exp_oor_data;
  logic        exp_err;

  initial begin
    for (int i = 0; i < 4; i++) src_arr[i] = '0;
    for (int i = 0; i < 3; i++) src3_arr[i] = '0;
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    bus3.in_valid = 1'b0; bus3.sel = 2'd0; bus3.out_ready = 1'b1; bus3.flush = 1'b0;

    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_sel", 64'(bus.out_sel), 64'(0));
    check("rst_occupancy", 64'(bus.occupancy), 64'(0));
    check("rst_sel_err", 64'(bus.sel_err), 64'(0));
    #9 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // 1: basic select
    src_arr[0] = 32'hAAAA_AAAA; src_arr[1] = 32'h5555_5555;
    drive(1'b1, 2'd1, 1'b1, 1'b0); tick();
    check("t1_data_a", 64'(bus.out_data), 64'h5555_5555);
    check("t1_sel_a", 64'(bus.out_sel), 64'(1));
    drive(1'b1, 2'd0, 1'b1, 1'b0); tick();
    check("t1_data_b", 64'(bus.out_data), 64'hAAAA_AAAA);
    check("t1_sel_b", 64'(bus.out_sel), 64'(0));
    drive(1'b0, 2'd0, 1'b1, 1'b0); tick();

    // 2: back-pressure
    src_arr[0] = 32'h1234_5678; src_arr[1] = 32'h8765_4321;
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick();
    check("t2_occ", 64'(bus.occupancy), 64'(2));
    check("t2_in_ready", 64'(bus.in_ready), 64'(0));
    check("t2_hold", 64'(bus.out_data), 64'h1234_5678);
    drive(1'b0, 2'd0, 1'b0, 1'b0); tick();
    check("t2_stable", 64'(bus.out_data), 64'h1234_5678);
    drive(1'b0, 2'd0, 1'b1, 1'b0); tick();
    check("t2_second", 64'(bus.out_data), 64'h8765_4321);
    check("t2_ready_after_pop", 64'(bus.in_ready), 64'(1));
    tick();
    check("t2_drained", 64'(bus.out_valid), 64'(0));

    // 3: back-to-back accept + pop in ONE
    src_arr[0] = 32'h0000_0001; src_arr[1] = 32'h0000_0002; src_arr[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 1'b1, 1'b0); tick();
      check("t3_data", 64'(bus.out_data), 64'(src_arr[i]));
      check("t3_occ", 64'(bus.occupancy), 64'(1));
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0); tick();

    // 4: flush while FULL with a concurrent request
    src_arr[3] = 32'hDEAD_BEEF;
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd3, 1'b0, 1'b1); tick();
    check("t4_valid", 64'(bus.out_valid), 64'(0));
    check("t4_occ", 64'(bus.occupancy), 64'(0));
    check("t4_in_ready", 64'(bus.in_ready), 64'(1));
    drive(1'b0, 2'd0, 1'b1, 1'b0); tick();
    check("t4_no_ghost", 64'(bus.out_valid), 64'(0));

    // 5: async reset while FULL
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    check("t5_valid", 64'(bus.out_valid), 64'(0));
    check("t5_data", 64'(bus.out_data), 64'(0));
    check("t5_occ", 64'(bus.occupancy), 64'(0));
    #1 rst_n = 1'b1;
    src_arr[2] = 32'h0000_0000;
    drive(1'b1, 2'd2, 1'b1, 1'b0); tick();
    check("t5_post_data", 64'(bus.out_data), 64'(0));
    check("t5_post_sel", 64'(bus.out_sel), 64'(2));
    check("t5_post_valid", 64'(bus.out_valid), 64'(1));

    // random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) src_arr[i] = $urandom;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0); tick(); tick();

    // 6: out-of-range select on a 3-source instance
    src3_arr[0] = 32'hCAFE_BABE; src3_arr[1] = 32'h1111_1111; src3_arr[2] = 32'h2222_2222;
`ifdef OPSEL_RANGE_CHK_EN
    exp_oor_data = 32'h0;
    exp_err = 1'b1;
`else
    exp_oor_data = 32'hCAFE_BABE;
    exp_err = 1'b0;
`endif
    check("t6_err_init", 64'(bus3.sel_err), 64'(0));
    bus3.sel = 2'd3; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    check("t6_valid", 64'(bus3.out_valid), 64'(1));
    check("t6_data", 64'(bus3.out_data), 64'(exp_oor_data));
    check("t6_sel", 64'(bus3.out_sel), 64'(3));
    @(posedge clk); #1;
    check("t6_err", 64'(bus3.sel_err), 64'(exp_err));
    bus3.sel = 2'd2; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    check("t6_inrange", 64'(bus3.out_data), 64'h2222_2222);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_sticky", 64'(bus3.sel_err), 64'(exp_err));
    check("t6_drained", 64'(bus3.out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
